// File: rtl/fp_accum_seq_pkg.sv
`default_nettype none
// =============================================================================
// fp_accum_seq_pkg : shared types and constants for the FP accumulator sequencer
// Revision: 1.0
// =============================================================================
package fp_accum_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT    = 16;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage
`default_nettype wire

// File: rtl/fp_accum_seq_if.sv
`default_nettype none
// =============================================================================
// fp_accum_seq_if : input stream, adder handshake and output stream bundle
// Revision: 1.0
// =============================================================================
interface fp_accum_seq_if #(
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;

    logic              add_start;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_done;
    logic [31:0]       add_sum;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, in_last, add_done, add_sum, out_ready,
        output in_ready, add_start, add_a, add_b, out_valid, out_data, out_count, out_err
    );

    modport master (
        output in_valid, in_data, in_last, add_done, add_sum, out_ready,
        input  in_ready, add_start, add_a, add_b, out_valid, out_data, out_count, out_err
    );
endinterface
`default_nettype wire

// File: rtl/fp_accum_seq_wdog.sv
`default_nettype none
// =============================================================================
// fp_accum_wdog : adder-wait watchdog; expire flags the MAX_WAIT-1'th enabled cycle
// Revision: 1.0
// =============================================================================
module fp_accum_wdog #(
    parameter int unsigned MAX_WAIT = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expire_o
);
    localparam int unsigned W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [W-1:0] C_LIMIT = W'(MAX_WAIT - 2);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // cnt_q holds completed wait cycles, so the current cycle is cnt_q+1 inclusive
    assign expire_o = en_i && (cnt_q == C_LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fp_accum_seq.sv
`default_nettype none
// =============================================================================
// fp_accum_seq : streaming FP accumulator sequencer driving an external adder
// Revision: 1.0
// =============================================================================
module fp_accum_seq
    import fp_accum_seq_pkg::*;
#(
    parameter int          CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fp_accum_seq_if.slave    bus
);
    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              last_q, last_d;

    logic              wd_clr;
    logic              wd_en;
    logic              wd_expire;
    logic              in_fire;

    assign in_fire = bus.in_valid && bus.in_ready;

    fp_accum_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        last_d  = last_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    acc_d   = bus.in_data;
                    cnt_d   = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = bus.in_last ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_fire) begin
                    opb_d   = bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.add_done) begin
                    acc_d   = bus.add_sum;
                    state_d = last_q ? ST_OUT : ST_ACC;
                end else begin
                    wd_clr  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // a done arriving with the timeout still counts as a good result
                if (bus.add_done) begin
                    acc_d   = bus.add_sum;
                    state_d = last_q ? ST_OUT : ST_ACC;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = !reset && (state_q == ST_IDLE || state_q == ST_ACC);
        bus.add_start = !reset && (state_q == ST_ISSUE);
        bus.add_a     = '0;
        bus.add_b     = '0;
        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            bus.add_a = acc_q;
            bus.add_b = opb_q;
        end
        bus.out_valid = !reset && (state_q == ST_OUT);
        bus.out_data  = (state_q == ST_OUT) ? acc_q : '0;
        bus.out_count = (state_q == ST_OUT) ? cnt_q : '0;
        bus.out_err   = (state_q == ST_OUT) && err_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_accum_seq.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_fp_accum_seq : directed bench with adder model and output scoreboard
// Revision: 1.0
// =============================================================================
module tb_fp_accum_seq;
    import fp_accum_seq_pkg::*;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 8;
    localparam int LAT      = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_accum_seq_if #(.CNT_W(CNT_W)) bus ();

    fp_accum_seq #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // adder model: known IEEE pairs by table, NaN operand a propagates, else integer add
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h7FC0_0000)                          return a;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000)    return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'h4040_0000)    return 32'h40C0_0000;
        if (a == 32'h3F80_0000 && b == 32'h0000_0000)    return 32'h3F80_0000;
        return a + b;
    endfunction

    int          mode  = 0;   // 0: LAT-cycle adder, 1: done in start cycle, 2: never done
    logic        stale = 1'b0;
    logic        busy;
    int          cd;
    logic [31:0] ra, rb;

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cd   <= 0;
        end else if (bus.add_start && mode == 0) begin
            busy <= 1'b1;
            cd   <= LAT - 1;
            ra   <= bus.add_a;
            rb   <= bus.add_b;
        end else if (busy) begin
            if (cd == 0) busy <= 1'b0;
            else         cd   <= cd - 1;
        end
    end

    always_comb begin
        bus.add_done = 1'b0;
        bus.add_sum  = 32'hDEAD_BEEF;
        if (mode == 1 && bus.add_start) begin
            bus.add_done = 1'b1;
            bus.add_sum  = fadd(bus.add_a, bus.add_b);
        end else if (busy && cd == 0) begin
            bus.add_done = 1'b1;
            bus.add_sum  = fadd(ra, rb);
        end else if (stale && !busy && !bus.add_start) begin
            bus.add_done = 1'b1;
        end
    end

    typedef struct {
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        logic             e;
    } exp_t;

    exp_t        sb[$];
    exp_t        ex;
    logic [31:0] op_a[$];
    logic [31:0] op_b[$];
    int          cyc = 0;
    int          n_starts = 0;
    int          start_cyc = 0;
    int          valid_cyc = 0;
    int          acc_cyc = 0;
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.add_start) begin
            n_starts++;
            start_cyc = cyc;
            op_a.push_back(bus.add_a);
            op_b.push_back(bus.add_b);
            if (prev_start) check("start_back_to_back", {31'b0, prev_start}, 32'd0);
        end
        prev_start = bus.add_start;
        if (bus.out_valid && !prev_valid) valid_cyc = cyc;
        prev_valid = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                ex = sb.pop_front();
                check("out_data",  bus.out_data, ex.d);
                check("out_count", 32'(bus.out_count), 32'(ex.c));
                check("out_err",   {31'b0, bus.out_err}, {31'b0, ex.e});
            end
        end
    end

    task automatic push(input logic [31:0] d, input int c, input logic e);
        exp_t t;
        t.d = d;
        t.c = CNT_W'(c);
        t.e = e;
        sb.push_back(t);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int   b;
        logic ok;
        b = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            b++;
        end while (!ok && b < 100);
        if (!ok) check("in_ready_timeout", {31'b0, ok}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0;
        int nv;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'b0, bus.in_ready}, 32'd0);
        check("rst_add_start", {31'b0, bus.add_start}, 32'd0);
        check("rst_add_a",     bus.add_a, FP_ZERO);
        check("rst_add_b",     bus.add_b, FP_ZERO);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data",  bus.out_data, FP_ZERO);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_out_err",   {31'b0, bus.out_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // three-word packet through the latency adder
        mode = 0;
        s0 = n_starts;
        op_a.delete();
        op_b.delete();
        push(32'h40C0_0000, 3, 1'b0);
        send(FP_ONE, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        wait_out();
        check("pkt3_starts", 32'(n_starts - s0), 32'd2);
        check("pkt3_a0", op_a[0], FP_ONE);
        check("pkt3_b0", op_b[0], 32'h4000_0000);
        check("pkt3_a1", op_a[1], 32'h4040_0000);
        check("pkt3_b1", op_b[1], 32'h4040_0000);

        // single-word packet
        s0 = n_starts;
        push(32'hBF80_0000, 1, 1'b0);
        send(32'hBF80_0000, 1'b1);
        wait_out();
        check("single_latency", 32'(valid_cyc - acc_cyc), 32'd1);
        check("single_starts", 32'(n_starts - s0), 32'd0);

        // done in the start cycle
        mode = 1;
        push(FP_ONE, 2, 1'b0);
        send(FP_ONE, 1'b0);
        send(FP_ZERO, 1'b1);
        wait_out();
        check("fast_latency", 32'(valid_cyc - acc_cyc), 32'd2);

        // hung adder
        mode = 2;
        push(FP_ONE, 2, 1'b1);
        send(FP_ONE, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_out();
        check("timeout_latency", 32'(valid_cyc - start_cyc), 32'd8);

        // stale done while idle/accumulating
        mode = 0;
        stale = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(32'h40C0_0000, 3, 1'b0);
        send(FP_ONE, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        wait_out();
        stale = 1'b0;

        // NaN passes through unchanged
        mode = 1;
        push(32'h7FC0_0000, 2, 1'b0);
        send(32'h7FC0_0000, 1'b0);
        send(FP_ONE, 1'b1);
        wait_out();

        // reset while waiting on the adder
        mode = 0;
        send(FP_ONE, 1'b0);
        send(32'h4000_0000, 1'b1);
        @(posedge clk);
        #1;
        check("wait_no_start", {31'b0, bus.add_start}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check("no_out_after_reset", 32'(nv), 32'd0);
        @(posedge clk);
        #1;
        push(32'h4040_0000, 2, 1'b0);
        send(FP_ONE, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_out();

        // consumer stall holds the result
        bus.out_ready = 1'b0;
        push(32'h4000_0000, 1, 1'b0);
        send(32'h4000_0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid",    {31'b0, bus.out_valid}, 32'd1);
            check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("stall_data",     bus.out_data, 32'h4000_0000);
            check("stall_count",    32'(bus.out_count), 32'd1);
            check("stall_err",      {31'b0, bus.out_err}, 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_out();

        // count saturation with 17 words into a 4-bit counter; sum 1..17 = 153
        mode = 1;
        push(32'd153, 15, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            send(32'(i), (i == 17));
        end
        wait_out();

        repeat (4) @(posedge clk);
        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
